// File: rtl/alu_wb_stage.sv
// alu_wb_stage: buffers ALU results for register write-back and holds the architectural flags
module alu_wb_stage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] S,
    input  logic              Cout,
    input  logic              Ov,
    input  logic              Neg,
    input  logic              Zero,
    input  logic [RA_W-1:0]   rd,
    input  logic              upd_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [RA_W-1:0]   wr_addr,
    output logic              wr_en,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              flag_v,
    output logic              ov_sticky,
    input  logic              clr_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W+RA_W-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   accept, pop;

    // handshakes come from the occupancy register only; the head is masked to zero when empty
    always_comb begin
        in_ready             = count != CW'(DEPTH);
        out_valid            = count != '0;
        accept               = in_valid & in_ready;
        pop                  = out_valid & out_ready;
        {wr_data, wr_addr}   = out_valid ? mem[rd_ptr] : '0;
        wr_en                = pop & (wr_addr != '0);
    end

    // entry storage; slots are only read after being written so they need no reset
    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {S, rd};

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(accept);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(accept) - CW'(pop);
        end

    // flags follow acceptance order, independent of when the entry drains
    always_ff @(posedge clk or posedge rst)
        if (rst) {flag_z, flag_c, flag_n, flag_v} <= '0;
        else if (accept & upd_flags) {flag_z, flag_c, flag_n, flag_v} <= {Zero, Cout, Neg, Ov};

    // sticky overflow: a new overflow beats a coincident clear
    always_ff @(posedge clk or posedge rst)
        if (rst) ov_sticky <= 1'b0;
        else if (accept & upd_flags & Ov) ov_sticky <= 1'b1;
        else if (clr_sticky) ov_sticky <= 1'b0;
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed scenarios plus a randomized stream against a queue/flag reference model
module tb_alu_wb_stage;
    localparam int DEPTH = 2;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, Cout = 0, Ov = 0, Neg = 0, Zero = 0, upd_flags = 0, out_ready = 0, clr_sticky = 0;
    logic [7:0] S = 0;
    logic [2:0] rd = 0;
    logic       in_ready, out_valid, wr_en, flag_z, flag_c, flag_n, flag_v, ov_sticky;
    logic [7:0] wr_data;
    logic [2:0] wr_addr;
    int tests = 0, fails = 0;

    alu_wb_stage #(.DATA_W(8), .DEPTH(DEPTH), .RA_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S(S), .Cout(Cout), .Ov(Ov),
        .Neg(Neg), .Zero(Zero), .rd(rd), .upd_flags(upd_flags), .out_valid(out_valid), .out_ready(out_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .flag_v(flag_v), .ov_sticky(ov_sticky), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] s, input logic [2:0] r, input logic u, input logic [3:0] zcnv);
        in_valid = 1; S = s; rd = r; upd_flags = u; {Zero, Cout, Neg, Ov} = zcnv;
    endtask

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        tests++; if ({in_ready, out_valid, wr_en} !== 3'b100) begin fails++; $display("FAIL reset_hs got %b want 100", {in_ready, out_valid, wr_en}); end
        tests++; if ({flag_z, flag_c, flag_n, flag_v, ov_sticky} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {flag_z, flag_c, flag_n, flag_v, ov_sticky}); end
        tests++; if ({wr_data, wr_addr} !== 11'b0) begin fails++; $display("FAIL reset_head got %h/%h want 0/0", wr_data, wr_addr); end
        @(negedge clk); rst = 0; #1;
    endtask

    task automatic test_single;
        out_ready = 1;
        push(8'h80, 3'd3, 1, 4'b0010);
        tick; in_valid = 0; #1;
        tests++; if ({out_valid, wr_en, wr_addr, wr_data} !== {2'b11, 3'd3, 8'h80}) begin fails++; $display("FAIL single got v%b en%b a%0d d%h want v1 en1 a3 d80", out_valid, wr_en, wr_addr, wr_data); end
        tests++; if ({flag_n, flag_z} !== 2'b10) begin fails++; $display("FAIL single_flags got n%b z%b want n1 z0", flag_n, flag_z); end
        tick;
        tests++; if (out_valid !== 0) begin fails++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        push(8'h11, 3'd1, 0, 4'b0); tick;
        push(8'h22, 3'd2, 0, 4'b0); tick;
        tests++; if (in_ready !== 0) begin fails++; $display("FAIL bp_full got %b want 0", in_ready); end
        push(8'h33, 3'd3, 0, 4'b0); tick;
        in_valid = 0; out_ready = 1; #1;
        tests++; if ({wr_en, wr_data} !== {1'b1, 8'h11}) begin fails++; $display("FAIL bp_first got en%b d%h want en1 d11", wr_en, wr_data); end
        tick;
        tests++; if ({in_ready, wr_data} !== {1'b1, 8'h22}) begin fails++; $display("FAIL bp_second got rdy%b d%h want rdy1 d22", in_ready, wr_data); end
        tick;
        tests++; if (out_valid !== 0) begin fails++; $display("FAIL bp_third_dropped got %b want 0", out_valid); end
    endtask

    task automatic test_r0;
        push(8'h55, 3'd0, 1, 4'b1100); tick; in_valid = 0; #1;
        tests++; if ({out_valid, wr_en} !== 2'b10) begin fails++; $display("FAIL r0_strobe got v%b en%b want v1 en0", out_valid, wr_en); end
        tests++; if ({flag_z, flag_c} !== 2'b11) begin fails++; $display("FAIL r0_flags got z%b c%b want 11", flag_z, flag_c); end
        tick;
        tests++; if (out_valid !== 0) begin fails++; $display("FAIL r0_drain got %b want 0", out_valid); end
        push(8'h00, 3'd4, 0, 4'b0011); tick; in_valid = 0; #1;
        tests++; if ({flag_z, flag_c, flag_n, flag_v} !== 4'b1100) begin fails++; $display("FAIL noupd_flags got %b want 1100", {flag_z, flag_c, flag_n, flag_v}); end
        tick;
    endtask

    task automatic test_sticky;
        clr_sticky = 1; tick; clr_sticky = 0;
        push(8'h80, 3'd1, 0, 4'b0011); tick;
        tests++; if (ov_sticky !== 0) begin fails++; $display("FAIL sticky_noupd got %b want 0", ov_sticky); end
        push(8'h80, 3'd1, 1, 4'b0011); tick;
        tests++; if ({flag_v, ov_sticky} !== 2'b11) begin fails++; $display("FAIL sticky_set got v%b s%b want 11", flag_v, ov_sticky); end
        push(8'h02, 3'd2, 1, 4'b0000); tick;
        tests++; if ({flag_v, ov_sticky} !== 2'b01) begin fails++; $display("FAIL sticky_hold got v%b s%b want 01", flag_v, ov_sticky); end
        in_valid = 0; clr_sticky = 1; tick;
        tests++; if (ov_sticky !== 0) begin fails++; $display("FAIL sticky_clr got %b want 0", ov_sticky); end
        push(8'h80, 3'd2, 1, 4'b0011); tick;
        tests++; if (ov_sticky !== 1) begin fails++; $display("FAIL sticky_set_wins got %b want 1", ov_sticky); end
        in_valid = 0; tick; clr_sticky = 0; tick;
    endtask

    task automatic test_full_simul;
        out_ready = 0;
        push(8'hA1, 3'd5, 0, 4'b0); tick;
        push(8'hB2, 3'd6, 0, 4'b0); tick;
        push(8'hCC, 3'd7, 0, 4'b0); out_ready = 1; #1;
        tests++; if ({in_ready, wr_en} !== 2'b01) begin fails++; $display("FAIL full_simul_hs got rdy%b en%b want 01", in_ready, wr_en); end
        tick; out_ready = 0; #1;
        tests++; if ({in_ready, out_valid, wr_data} !== {2'b11, 8'hB2}) begin fails++; $display("FAIL full_simul_pop got rdy%b v%b d%h want 11 B2", in_ready, out_valid, wr_data); end
        tick; in_valid = 0;
        tests++; if ({in_ready, wr_data} !== {1'b0, 8'hB2}) begin fails++; $display("FAIL full_next_accept got rdy%b d%h want 0 B2", in_ready, wr_data); end
        out_ready = 1; tick;
        tests++; if ({wr_data, wr_addr} !== {8'hCC, 3'd7}) begin fails++; $display("FAIL full_order got %h/%0d want CC/7", wr_data, wr_addr); end
        tick;
    endtask

    task automatic test_async_reset;
        out_ready = 0;
        push(8'h10, 3'd1, 1, 4'b0101); tick;
        push(8'h20, 3'd2, 1, 4'b0100); tick; in_valid = 0;
        tests++; if ({out_valid, flag_c, ov_sticky} !== 3'b111) begin fails++; $display("FAIL pre_reset got %b want 111", {out_valid, flag_c, ov_sticky}); end
        #1 rst = 1; #1;
        tests++; if ({out_valid, flag_c, ov_sticky, in_ready} !== 4'b0001) begin fails++; $display("FAIL async_reset got %b want 0001", {out_valid, flag_c, ov_sticky, in_ready}); end
        @(negedge clk); rst = 0; out_ready = 1; push(8'h3C, 3'd4, 0, 4'b0); #1;
        tests++; if ({wr_en, out_valid} !== 2'b00) begin fails++; $display("FAIL post_reset_strobe got %b want 00", {wr_en, out_valid}); end
        tick; in_valid = 0;
        tests++; if ({out_valid, wr_data, wr_addr} !== {1'b1, 8'h3C, 3'd4}) begin fails++; $display("FAIL first_accept got v%b %h/%0d want 1 3C/4", out_valid, wr_data, wr_addr); end
        tick;
    endtask

    task automatic test_random;
        logic [10:0] q[$];
        logic [3:0]  m_flags;
        logic        m_sticky, acc, pp;
        logic [10:0] head;
        logic [18:0] obs, exp_v;
        int          errs;
        errs = 0;
        rst = 1; #1; @(negedge clk); rst = 0;
        m_flags = 0; m_sticky = 0;
        for (int i = 0; i < 10000; i++) begin
            in_valid = $urandom_range(0, 3) != 0; out_ready = $urandom_range(0, 1); clr_sticky = $urandom_range(0, 15) == 0;
            upd_flags = $urandom_range(0, 1); S = 8'($urandom); rd = 3'($urandom); {Zero, Cout, Neg, Ov} = 4'($urandom);
            #1;
            head  = q.size() != 0 ? q[0] : 11'b0;
            exp_v = {q.size() != DEPTH, q.size() != 0, q.size() != 0 && out_ready && head[2:0] != 0, head, m_flags, m_sticky};
            obs   = {in_ready, out_valid, wr_en, q.size() != 0 ? {wr_data, wr_addr} : 11'b0, flag_z, flag_c, flag_n, flag_v, ov_sticky};
            tests++;
            if (obs !== exp_v) begin
                fails++; errs++;
                if (errs <= 10) $display("FAIL random cycle %0d got %h want %h", i, obs, exp_v);
            end
            acc = in_valid && q.size() < DEPTH;
            pp  = out_ready && q.size() > 0;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back({S, rd});
            if (acc && upd_flags) m_flags = {Zero, Cout, Neg, Ov};
            if (acc && upd_flags && Ov) m_sticky = 1;
            else if (clr_sticky) m_sticky = 0;
            @(negedge clk);
        end
        in_valid = 0; clr_sticky = 0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_r0;
        test_sticky;
        test_full_simul;
        test_async_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
